// File: rtl/uart_rx_sampler_if.sv
// Byte-side bundle of uart_rx_sampler: received byte handshake plus status/error pulses.
// Handshake: data_out is meaningful while valid_out=1; a transfer happens on any clock edge where valid_out=1 and ready_in=1.
interface uart_rx_sampler_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 frame_err_out;
  logic                 overrun_err_out;
  logic                 busy_out;
  logic                 parity_err_out;

  modport master (
    output data_out, valid_out, frame_err_out, overrun_err_out, busy_out, parity_err_out,
    input  ready_in
  );

  modport slave (
    input  data_out, valid_out, frame_err_out, overrun_err_out, busy_out, parity_err_out,
    output ready_in
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: synchroniser, tick generator, 3-sample majority vote, deframing FSM, valid/ready output.
// Optional parity bit checking is compiled in with the UART_RX_PARITY_EN macro.
module uart_rx_sampler #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              sig_in,
  uart_rx_sampler_if.master rx,
  output logic [2:0]        state_dbg_out
);
  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_BITS);
  localparam logic [OS_W-1:0] V0   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] V1   = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] V2   = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0] LAST = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]        os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]             samp_q, samp_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit_q, par_bit_d;
  logic                   parity_err_q, parity_err_d;
`endif

  logic rx_s, tick, vote_tick, end_bit, maj, done_ok, stop_decide;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign tick      = (div_cnt_q == DIV_W'(DIV - 1));
  assign vote_tick = tick && (os_cnt_q == V2);
  assign end_bit   = tick && (os_cnt_q == LAST);
  assign maj       = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);

  // State register (also holds all datapath flops)
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      sync_q       <= '1;
      rx_prev_q    <= 1'b1;
      div_cnt_q    <= '0;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      samp_q       <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      rx_prev_q    <= rx_prev_d;
      div_cnt_q    <= div_cnt_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_q       <= samp_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], sig_in};
    rx_prev_d   = rx_s;
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    os_cnt_d    = tick ? os_cnt_q + 1'b1 : os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    samp_d      = samp_q;
    shreg_d     = shreg_q;
    done_ok     = 1'b0;
    stop_decide = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d   = par_bit_q;
`endif
    if (end_bit) os_cnt_d = '0;
    if (tick && (os_cnt_q == V0 || os_cnt_q == V1)) samp_d = {samp_q[0], rx_s};

    case (state_q)
      ST_IDLE: begin
        // Restart the bit timing on the edge so votes land mid-bit.
        if (rx_prev_q && !rx_s) begin
          state_d   = ST_START;
          div_cnt_d = '0;
          os_cnt_d  = '0;
        end
      end
      ST_START: begin
        if (vote_tick && maj) begin
          state_d = ST_IDLE;
        end else if (end_bit) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (vote_tick) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (end_bit) begin
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (vote_tick) par_bit_d = maj;
        if (end_bit) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Leaving at mid-stop lets IDLE catch a back-to-back start edge.
        if (vote_tick) begin
          stop_decide = 1'b1;
          done_ok     = maj;
          state_d     = maj ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d     = valid_q;
    data_d      = data_q;
    overrun_d   = 1'b0;
    frame_err_d = stop_decide && !maj;
    if (valid_q && rx.ready_in) valid_d = 1'b0;
    if (done_ok) begin
      if (!valid_q || rx.ready_in) begin
        valid_d = 1'b1;
        data_d  = shreg_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
`ifdef UART_RX_PARITY_EN
    parity_err_d = stop_decide && ((^shreg_q) ^ par_bit_q ^ PARITY_ODD);
`endif
  end

  // Outputs
  always_comb begin
    rx.busy_out   = (state_q != ST_IDLE);
    state_dbg_out = state_q;
  end

  assign rx.data_out        = data_q;
  assign rx.valid_out       = valid_q;
  assign rx.frame_err_out   = frame_err_q;
  assign rx.overrun_err_out = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign rx.parity_err_out  = parity_err_q;
`else
  assign rx.parity_err_out  = 1'b0;
`endif
endmodule
